pc_branch_unit: RTL
===================

Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage that sits directly downstream of the CPU control FSM.
- Consumes the FSM's PC-advance and flag-latch strobes, and holds the processor status flags.
- Decodes the current instruction word for Bcond/Jcond, evaluates the condition, and produces the next fetch address for instruction memory.

Parameters:
- ADDR_W, 16, width of PC and of instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_enable  in  1  advance strobe from control FSM (high during decode state).
- flags_enable  in  1  when high, flags register loads flags_in this edge.
- flags_in  in  5  ALU flags {C,L,F,Z,N}, bit4..bit0.
- instr  in  16  current instruction register contents.
- rtarget  in  16  register-file read value used as Jcond target.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus1  out  ADDR_W  pc+1, combinational, modulo 2^ADDR_W.
- flags  out  5  registered status flags {C,L,F,Z,N}.
- taken  out  1  registered; 1 if the last pc_enable update redirected the PC.
- halted  out  1  sticky; set by a taken branch/jump whose target equals the current pc.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, flags=5'b0, taken=0, halted=0. Release is synchronous to the next rising edge; no update on the edge coincident with release if reset is still low at that edge.
- Decode is combinational on instr:
  - Bcond: instr[15:12]=4'b1100, cond=instr[11:8], disp=instr[7:0] signed.
  - Jcond: instr[15:12]=4'b0100 and instr[7:4]=4'b1100, cond=instr[11:8].
  - Anything else is a non-branch.
- Condition codes, evaluated against the registered flags:
  - EQ 0000: Z=1. NE 0001: Z=0.
  - CS 0010: C=1. CC 0011: C=0.
  - HI 0100: L=1. LS 0101: L=0.
  - GT 0110: N=1. LE 0111: N=0.
  - FS 1000: F=1. FC 1001: F=0.
  - LO 1010: L=0 and Z=0. HS 1011: L=1 or Z=1.
  - LT 1100: N=0 and Z=0. GE 1101: N=1 or Z=1.
  - UC 1110: always. 1111: never.
- Next-PC on a rising edge with pc_enable=1:
  - Taken Bcond: pc <= pc + sext16(disp), truncated to ADDR_W, wraps modulo 2^ADDR_W.
  - Taken Jcond: pc <= rtarget[ADDR_W-1:0].
  - Otherwise: pc <= pc+1 (0xFFFF+1 wraps to 0x0000).
  - taken <= 1 if redirected, else 0.
  - If taken and target==pc, halted <= 1.
- pc_enable=0: pc, taken and halted hold.
- flags_enable=1: flags <= flags_in on that edge, independent of pc_enable.
- Simultaneous pc_enable and flags_enable: the condition uses the pre-edge (old) flags; the new flags are visible from the next cycle.
- Latency: a redirect appears on pc one edge after the pc_enable-high edge, i.e. the fetch of the following instruction sees the new address.
- halted clears only on reset. It is informational and never blocks pc updates.
- Reset mid-operation: all state returns to reset values immediately, regardless of pc_enable or flags_enable.
- Unknown/reserved instr encodings are treated as non-branch (pc+1); no error output.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants OP_BCOND=4'b1100, OP_REGEXT=4'b0100, EXT_JCOND=4'b1100.
  - The 16 condition-code constants.
  - Flag bit indices FLG_C=4, FLG_L=3, FLG_F=2, FLG_Z=1, FLG_N=0.
- One sub-module is natural: cond_eval, a combinational block mapping (cond[3:0], flags[4:0]) to a single true bit. It is reused later by Scond.
- The top level holds the pc, flags, taken and halted registers plus the next-PC mux.

Test Plan:
- Reset then pc_enable high for 3 edges with instr=0x0000 -> pc sequence 0x0000, 0x0001, 0x0002, 0x0003; taken=0, flags=0.
- flags_in=5'b00010 with flags_enable=1, then Bcond EQ disp=0xFE at pc=0x0010 with pc_enable -> pc=0x000E, taken=1; repeat with NE -> pc=0x000F, taken=0.
- Same edge: flags_enable=1 with flags_in Z=1 (old Z=0) and pc_enable=1 with BEQ -> not taken (old flags used); the next BEQ is taken.
- Jcond UC with rtarget=0x1234 -> pc=0x1234, taken=1; then BUC disp=0x00 at pc=0x1234 -> pc stays 0x1234, halted=1, and halted stays 1 through later pc+1 updates.
- pc=0xFFFF with non-branch -> pc=0x0000; pc=0x0005 with BUC disp=0x80 -> pc=0xFF85.
- Assert reset low mid-run at pc=0x0042 with flags=5'b11111 between clock edges -> pc=0x0000, flags=0, taken=0, halted=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the program-counter / branch-resolution stage:
// opcode fields, condition codes, flag bit positions and the branch decoder.
package pc_branch_unit_pkg;

  // Major opcode (instr[15:12]) and register-extended sub-opcode (instr[7:4])
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_REGEXT = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Positions of the status flags inside the 5-bit {C,L,F,Z,N} vector
  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  // Condition codes carried in instr[11:8] of Bcond/Jcond (and later Scond)
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_HI = 4'b0100,
    COND_LS = 4'b0101,
    COND_GT = 4'b0110,
    COND_LE = 4'b0111,
    COND_FS = 4'b1000,
    COND_FC = 4'b1001,
    COND_LO = 4'b1010,
    COND_HS = 4'b1011,
    COND_LT = 4'b1100,
    COND_GE = 4'b1101,
    COND_UC = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // What kind of control transfer the current instruction word describes
  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_BCOND = 2'b01,
    BR_JCOND = 2'b10
  } br_kind_e;

  typedef struct packed {
    br_kind_e   kind;
    logic [3:0] cond;
    logic [7:0] disp;
  } br_decode_t;

  // Classify an instruction word; anything not recognised is a plain
  // sequential instruction, so reserved encodings simply fall through to pc+1.
  function automatic br_decode_t decodeInstr(input logic [15:0] instr);
    br_decode_t d;
    d.cond = instr[11:8];
    d.disp = instr[7:0];
    if (instr[15:12] == OP_BCOND) begin
      d.kind = BR_BCOND;
    end else if ((instr[15:12] == OP_REGEXT) && (instr[7:4] == EXT_JCOND)) begin
      d.kind = BR_JCOND;
    end else begin
      d.kind = BR_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Bundle between the control FSM / datapath and the PC-branch unit.
// The master side supplies strobes and operands; the slave side returns the
// fetch address and status.
interface pc_branch_unit_if #(
  parameter int ADDR_W = 16
);

  logic              pc_enable;
  logic              flags_enable;
  logic [4:0]        flags_in;
  logic [15:0]       instr;
  logic [15:0]       rtarget;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [4:0]        flags;
  logic              taken;
  logic              halted;

  modport master (
    output pc_enable,
    output flags_enable,
    output flags_in,
    output instr,
    output rtarget,
    input  pc,
    input  pc_plus1,
    input  flags,
    input  taken,
    input  halted
  );

  modport slave (
    input  pc_enable,
    input  flags_enable,
    input  flags_in,
    input  instr,
    input  rtarget,
    output pc,
    output pc_plus1,
    output flags,
    output taken,
    output halted
  );

endinterface

// File: rtl/pc_branch_unit_cond_eval.sv
// Combinational condition evaluator: maps a 4-bit condition code and the
// {C,L,F,Z,N} flags to a single "condition holds" bit.
module pc_branch_unit_cond_eval
  import pc_branch_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       true_o
);

  logic flagC;
  logic flagL;
  logic flagF;
  logic flagZ;
  logic flagN;

  assign flagC = flags_i[FLG_C];
  assign flagL = flags_i[FLG_L];
  assign flagF = flags_i[FLG_F];
  assign flagZ = flags_i[FLG_Z];
  assign flagN = flags_i[FLG_N];

  // Truth table of the condition codes; the code space is fully populated.
  always_comb begin
    true_o = 1'b0;
    case (cond_i)
      COND_EQ: true_o = flagZ;
      COND_NE: true_o = ~flagZ;
      COND_CS: true_o = flagC;
      COND_CC: true_o = ~flagC;
      COND_HI: true_o = flagL;
      COND_LS: true_o = ~flagL;
      COND_GT: true_o = flagN;
      COND_LE: true_o = ~flagN;
      COND_FS: true_o = flagF;
      COND_FC: true_o = ~flagF;
      COND_LO: true_o = ~flagL & ~flagZ;
      COND_HS: true_o = flagL | flagZ;
      COND_LT: true_o = ~flagN & ~flagZ;
      COND_GE: true_o = flagN | flagZ;
      COND_UC: true_o = 1'b1;
      COND_NV: true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter and branch-resolution stage. Holds the PC and the status
// flags, resolves Bcond/Jcond against the registered flags and produces the
// next fetch address. Flags written on the same edge as a PC advance only
// influence the following instruction.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  pc_branch_unit_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [4:0]        flags_q;
  logic              taken_q;
  logic              taken_d;
  logic              halted_q;
  logic              halted_d;

  br_decode_t        dec;
  logic              condTrue;
  logic              redirect;
  logic [15:0]       dispExt;
  logic [ADDR_W-1:0] pcPlus1;
  logic [ADDR_W-1:0] branchTarget;
  logic [ADDR_W-1:0] jumpTarget;
  logic [ADDR_W-1:0] redirectTarget;

  assign dec = decodeInstr(bus.instr);

  pc_branch_unit_cond_eval u_cond_eval (
    .cond_i  (dec.cond),
    .flags_i (flags_q),
    .true_o  (condTrue)
  );

  // Sign-extend the 8-bit displacement to 16 bits, then let the PC-width
  // addition wrap naturally.
  assign dispExt      = {{8{dec.disp[7]}}, dec.disp};
  assign pcPlus1      = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign branchTarget = pc_q + dispExt[ADDR_W-1:0];
  assign jumpTarget   = bus.rtarget[ADDR_W-1:0];

  // Next-PC selection; a redirect onto the current PC marks the self-loop halt.
  always_comb begin
    redirect       = 1'b0;
    redirectTarget = jumpTarget;
    case (dec.kind)
      BR_BCOND: begin
        redirect       = condTrue;
        redirectTarget = branchTarget;
      end
      BR_JCOND: begin
        redirect       = condTrue;
        redirectTarget = jumpTarget;
      end
      default: begin
        redirect       = 1'b0;
        redirectTarget = jumpTarget;
      end
    endcase
    pc_d     = redirect ? redirectTarget : pcPlus1;
    taken_d  = redirect;
    halted_d = halted_q | (redirect && (redirectTarget == pc_q));
  end

  // PC/taken/halted advance only on the FSM strobe; flags load independently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      flags_q  <= 5'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (bus.pc_enable) begin
        pc_q     <= pc_d;
        taken_q  <= taken_d;
        halted_q <= halted_d;
      end
      if (bus.flags_enable) begin
        flags_q <= bus.flags_in;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pcPlus1;
  assign bus.flags    = flags_q;
  assign bus.taken    = taken_q;
  assign bus.halted   = halted_q;

endmodule
